// File: rtl/mc_control_pkg.sv
// mc_control_pkg
// Shared definitions for the multicycle control slice: the existing ALU
// function codes, the 4-bit binary FSM state encoding, and the opcode and
// funct field values the controller recognises.
package mc_control_pkg;

  // Field widths of the ALU func interface and the instruction fields.
  localparam int FUNC_W_DEF = 4;
  localparam int OP_W_DEF   = 6;

  // ALU function codes. These are the existing datapath codes; the
  // controller never invents new ones.
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;

  // Primary opcodes, IR[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, IR[5:0].
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  // Controller states, 4-bit binary encoding. Codes 13..15 are unused.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC     = 4'd2,
    ST_ALU_WB   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WB   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

endpackage

// File: rtl/mc_control_alu_ctrl_decode.sv
// alu_ctrl_decode
// Combinational R-type funct decoder used by the controller in EXEC.
// Maps the funct field onto an ALU function code and flags whether the
// funct is one the datapath supports.
// Ports:
//   funct    in   OP_W    IR[5:0]
//   alu_func out  FUNC_W  ALU code for the funct (ADD when unsupported)
//   legal    out  1       1 when funct is ADD/SUB/AND/OR
import mc_control_pkg::*;

module alu_ctrl_decode #(
  parameter int FUNC_W = FUNC_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   funct,
  output logic [FUNC_W-1:0] alu_func,
  output logic              legal
);

  // Funct lookup; an unsupported funct still yields a harmless ADD code.
  always_comb begin
    alu_func = ALU_ADD;
    legal    = 1'b0;
    case (funct)
      FN_ADD: begin alu_func = ALU_ADD; legal = 1'b1; end
      FN_SUB: begin alu_func = ALU_SUB; legal = 1'b1; end
      FN_AND: begin alu_func = ALU_AND; legal = 1'b1; end
      FN_OR:  begin alu_func = ALU_OR;  legal = 1'b1; end
      default: begin
        alu_func = ALU_ADD;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control
// Multicycle control FSM for the 32-bit datapath. Decodes opcode/funct and
// sequences FETCH..WRITEBACK, driving the ALU func code, operand selects and
// datapath write enables each cycle. Outputs are a Moore decode of the state
// register, except the two handshake-driven enables: pc_write/ir_write in
// FETCH follow mem_ready, and pc_write in BRANCH follows isZero.
// Ports:
//   clk, rst                   clock, async active-high reset
//   opcode, funct              instruction fields from the IR
//   isZero                     ALU zero flag (used in BRANCH only)
//   mem_ready                  memory access completes when 1
//   alu_func                   ALU function code
//   alu_src_a, alu_src_b       ALU operand selects
//   pc_source                  PC input select
//   pc_write, ir_write         PC / IR load enables
//   iord, mem_read, mem_write  memory address select and requests
//   reg_dst, mem_to_reg        register write destination / data select
//   reg_write                  register file write enable
//   illegal                    sticky unsupported-instruction flag
import mc_control_pkg::*;

module mc_control #(
  parameter int FUNC_W = FUNC_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic [OP_W-1:0]   funct,
  input  logic              isZero,
  input  logic              mem_ready,
  output logic [FUNC_W-1:0] alu_func,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_source,
  output logic              pc_write,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              illegal
);

  state_t             state_r;
  state_t             next_state_s;
  logic               illegal_r;
  logic [FUNC_W-1:0]  dec_func_s;
  logic               dec_legal_s;

  alu_ctrl_decode #(
    .FUNC_W (FUNC_W),
    .OP_W   (OP_W)
  ) u_alu_ctrl_decode (
    .funct    (funct),
    .alu_func (dec_func_s),
    .legal    (dec_legal_s)
  );

  // State register and sticky illegal flag; reset returns to FETCH at once,
  // which also withdraws any pending memory request in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      illegal_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == ST_TRAP) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: next_state_s = ST_EXEC;
          OP_LW:    next_state_s = ST_MEM_ADDR;
          OP_SW:    next_state_s = ST_MEM_ADDR;
          OP_BEQ:   next_state_s = ST_BRANCH;
          OP_J:     next_state_s = ST_JUMP;
          OP_ADDI:  next_state_s = ST_ADDI_EX;
          default:  next_state_s = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        // An unsupported funct traps before any writeback is reached.
        if (dec_legal_s) begin
          next_state_s = ST_ALU_WB;
        end else begin
          next_state_s = ST_TRAP;
        end
      end
      ST_ALU_WB: next_state_s = ST_FETCH;
      ST_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          next_state_s = ST_MEM_RD;
        end else if (opcode == OP_SW) begin
          next_state_s = ST_MEM_WR;
        end else begin
          next_state_s = ST_TRAP;
        end
      end
      ST_MEM_RD: begin
        if (mem_ready) begin
          next_state_s = ST_MEM_WB;
        end else begin
          next_state_s = ST_MEM_RD;
        end
      end
      ST_MEM_WB: next_state_s = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM_WR;
        end
      end
      ST_BRANCH:  next_state_s = ST_FETCH;
      ST_JUMP:    next_state_s = ST_FETCH;
      ST_ADDI_EX: next_state_s = ST_ADDI_WB;
      ST_ADDI_WB: next_state_s = ST_FETCH;
      ST_TRAP:    next_state_s = ST_TRAP;
      // Unused encodings are treated as a corrupted state and trapped.
      default:    next_state_s = ST_TRAP;
    endcase
  end

  // Per-state output decode; everything not listed for a state stays 0
  // and the ALU defaults to ADD.
  always_comb begin
    alu_func   = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_source  = 2'd0;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // PC+4 is computed every cycle but only loaded once the fetch lands.
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b = 2'd3;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_func  = dec_func_s;
      end
      ST_ALU_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_func  = ALU_SUB;
        pc_source = 2'd1;
        pc_write  = isZero;
      end
      ST_JUMP: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
      end
      ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
      end
      ST_TRAP: begin
        alu_func = ALU_ADD;
      end
      default: begin
        alu_func = ALU_ADD;
      end
    endcase
  end

  assign illegal = illegal_r;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
// Directed bench for mc_control. The driver issues one cycle of inputs at a
// time and pushes the hand-derived output vector for that cycle into a
// queue; a monitor on the falling edge pops and compares.
import mc_control_pkg::*;

module tb_mc_control;

  typedef struct packed {
    logic       illegal;
    logic [3:0] alu_func;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } outs_t;

  typedef struct {
    outs_t v;
    string name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       isZero;
  logic       mem_ready;
  logic [3:0] alu_func;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  mc_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .isZero     (isZero),
    .mem_ready  (mem_ready),
    .alu_func   (alu_func),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write}
  function automatic outs_t mk(input logic ill, input logic [3:0] fn, input logic sa,
                               input logic [1:0] sb, input logic [1:0] ps, input logic [7:0] en);
    outs_t o;
    o.illegal    = ill;
    o.alu_func   = fn;
    o.src_a      = sa;
    o.src_b      = sb;
    o.pc_source  = ps;
    o.pc_write   = en[7];
    o.iord       = en[6];
    o.mem_read   = en[5];
    o.mem_write  = en[4];
    o.ir_write   = en[3];
    o.reg_dst    = en[2];
    o.mem_to_reg = en[1];
    o.reg_write  = en[0];
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o = {illegal, alu_func, alu_src_a, alu_src_b, pc_source, pc_write, iord,
         mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write};
    return o;
  endfunction

  // Hand-derived expected vectors per control step.
  outs_t e_fetch_go, e_fetch_wait, e_decode, e_exec_add, e_exec_sub, e_exec_and, e_exec_or;
  outs_t e_alu_wb, e_mem_addr, e_mem_rd, e_mem_wb, e_mem_wr, e_br_taken, e_br_not;
  outs_t e_jump, e_addi_ex, e_addi_wb, e_trap;

  // Monitor: compare one queued expectation per cycle, away from the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      outs_t got;
      e   = sb_q.pop_front();
      got = sample();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.name, got, e.v);
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input outs_t ev, input string name);
    exp_t e;
    opcode    = op;
    funct     = fn;
    isZero    = z;
    mem_ready = rdy;
    e.v    = ev;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic direct_check(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    e_fetch_go   = mk(1'b0, ALU_ADD, 1'b0, 2'd1, 2'd0, 8'b1010_1000);
    e_fetch_wait = mk(1'b0, ALU_ADD, 1'b0, 2'd1, 2'd0, 8'b0010_0000);
    e_decode     = mk(1'b0, ALU_ADD, 1'b0, 2'd3, 2'd0, 8'b0000_0000);
    e_exec_add   = mk(1'b0, ALU_ADD, 1'b1, 2'd0, 2'd0, 8'b0000_0000);
    e_exec_sub   = mk(1'b0, ALU_SUB, 1'b1, 2'd0, 2'd0, 8'b0000_0000);
    e_exec_and   = mk(1'b0, ALU_AND, 1'b1, 2'd0, 2'd0, 8'b0000_0000);
    e_exec_or    = mk(1'b0, ALU_OR,  1'b1, 2'd0, 2'd0, 8'b0000_0000);
    e_alu_wb     = mk(1'b0, ALU_ADD, 1'b0, 2'd0, 2'd0, 8'b0000_0101);
    e_mem_addr   = mk(1'b0, ALU_ADD, 1'b1, 2'd2, 2'd0, 8'b0000_0000);
    e_mem_rd     = mk(1'b0, ALU_ADD, 1'b0, 2'd0, 2'd0, 8'b0110_0000);
    e_mem_wb     = mk(1'b0, ALU_ADD, 1'b0, 2'd0, 2'd0, 8'b0000_0011);
    e_mem_wr     = mk(1'b0, ALU_ADD, 1'b0, 2'd0, 2'd0, 8'b0101_0000);
    e_br_taken   = mk(1'b0, ALU_SUB, 1'b1, 2'd0, 2'd1, 8'b1000_0000);
    e_br_not     = mk(1'b0, ALU_SUB, 1'b1, 2'd0, 2'd1, 8'b0000_0000);
    e_jump       = mk(1'b0, ALU_ADD, 1'b0, 2'd0, 2'd2, 8'b1000_0000);
    e_addi_ex    = mk(1'b0, ALU_ADD, 1'b1, 2'd2, 2'd0, 8'b0000_0000);
    e_addi_wb    = mk(1'b0, ALU_ADD, 1'b0, 2'd0, 2'd0, 8'b0000_0001);
    e_trap       = mk(1'b1, ALU_ADD, 1'b0, 2'd0, 2'd0, 8'b0000_0000);

    rst = 1'b1; opcode = 6'h00; funct = 6'h00; isZero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    // Reset state: FETCH outputs, illegal clear.
    step(6'h00, 6'h00, 1'b0, 1'b0, e_fetch_wait, "reset_fetch");
    rst = 1'b0;

    // add, then sub/and/or, all with mem_ready tied high (4 cycles each).
    step(OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_fetch_go, "add_fetch");
    step(OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_decode,   "add_decode");
    step(OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_exec_add, "add_exec");
    step(OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_alu_wb,   "add_wb");
    step(OP_RTYPE, FN_SUB, 1'b0, 1'b1, e_fetch_go, "sub_fetch");
    step(OP_RTYPE, FN_SUB, 1'b0, 1'b1, e_decode,   "sub_decode");
    step(OP_RTYPE, FN_SUB, 1'b0, 1'b1, e_exec_sub, "sub_exec");
    step(OP_RTYPE, FN_SUB, 1'b0, 1'b1, e_alu_wb,   "sub_wb");
    step(OP_RTYPE, FN_AND, 1'b0, 1'b1, e_fetch_go, "and_fetch");
    step(OP_RTYPE, FN_AND, 1'b0, 1'b1, e_decode,   "and_decode");
    step(OP_RTYPE, FN_AND, 1'b0, 1'b1, e_exec_and, "and_exec");
    step(OP_RTYPE, FN_AND, 1'b0, 1'b1, e_alu_wb,   "and_wb");
    step(OP_RTYPE, FN_OR,  1'b0, 1'b1, e_fetch_go, "or_fetch");
    step(OP_RTYPE, FN_OR,  1'b0, 1'b1, e_decode,   "or_decode");
    step(OP_RTYPE, FN_OR,  1'b0, 1'b1, e_exec_or,  "or_exec");
    step(OP_RTYPE, FN_OR,  1'b0, 1'b1, e_alu_wb,   "or_wb");

    // lw with three wait cycles in MEM_RD: request held 4 cycles.
    step(OP_LW, 6'h00, 1'b0, 1'b1, e_fetch_go, "lw_fetch");
    step(OP_LW, 6'h00, 1'b0, 1'b1, e_decode,   "lw_decode");
    step(OP_LW, 6'h00, 1'b0, 1'b1, e_mem_addr, "lw_addr");
    for (int i = 0; i < 3; i++) begin
      step(OP_LW, 6'h00, 1'b0, 1'b0, e_mem_rd, "lw_rd_wait");
    end
    step(OP_LW, 6'h00, 1'b0, 1'b1, e_mem_rd, "lw_rd_done");
    step(OP_LW, 6'h00, 1'b0, 1'b1, e_mem_wb, "lw_wb");

    // sw with immediate handshake: 4 cycles.
    step(OP_SW, 6'h00, 1'b0, 1'b1, e_fetch_go, "sw_fetch");
    step(OP_SW, 6'h00, 1'b0, 1'b1, e_decode,   "sw_decode");
    step(OP_SW, 6'h00, 1'b0, 1'b1, e_mem_addr, "sw_addr");
    step(OP_SW, 6'h00, 1'b0, 1'b1, e_mem_wr,   "sw_wr");

    // beq taken and not taken: 3 cycles each.
    step(OP_BEQ, 6'h00, 1'b1, 1'b1, e_fetch_go, "beq1_fetch");
    step(OP_BEQ, 6'h00, 1'b1, 1'b1, e_decode,   "beq1_decode");
    step(OP_BEQ, 6'h00, 1'b1, 1'b1, e_br_taken, "beq1_branch");
    step(OP_BEQ, 6'h00, 1'b0, 1'b1, e_fetch_go, "beq0_fetch");
    step(OP_BEQ, 6'h00, 1'b0, 1'b1, e_decode,   "beq0_decode");
    step(OP_BEQ, 6'h00, 1'b0, 1'b1, e_br_not,   "beq0_branch");

    // addi: 4 cycles.
    step(OP_ADDI, 6'h00, 1'b0, 1'b1, e_fetch_go, "addi_fetch");
    step(OP_ADDI, 6'h00, 1'b0, 1'b1, e_decode,   "addi_decode");
    step(OP_ADDI, 6'h00, 1'b0, 1'b1, e_addi_ex,  "addi_ex");
    step(OP_ADDI, 6'h00, 1'b0, 1'b1, e_addi_wb,  "addi_wb");

    // j, then a slow fetch that waits two cycles with iord=0.
    step(OP_J, 6'h00, 1'b0, 1'b1, e_fetch_go, "j_fetch");
    step(OP_J, 6'h00, 1'b0, 1'b1, e_decode,   "j_decode");
    step(OP_J, 6'h00, 1'b0, 1'b1, e_jump,     "j_jump");
    step(OP_J, 6'h00, 1'b0, 1'b0, e_fetch_wait, "post_j_wait0");
    step(OP_J, 6'h00, 1'b0, 1'b0, e_fetch_wait, "post_j_wait1");
    step(OP_J, 6'h00, 1'b0, 1'b1, e_fetch_go,   "post_j_fetch");

    // sw stalled in MEM_WR, then reset mid-access.
    step(OP_SW, 6'h00, 1'b0, 1'b1, e_decode,   "sw2_decode");
    step(OP_SW, 6'h00, 1'b0, 1'b1, e_mem_addr, "sw2_addr");
    step(OP_SW, 6'h00, 1'b0, 1'b0, e_mem_wr,   "sw2_wr_wait");
    #2;
    rst = 1'b1;
    #1;
    direct_check("rst_mem_write_drop", {17'd0, mem_write}, 18'd0);
    direct_check("rst_outs_fetch", sample(), e_fetch_wait);
    @(posedge clk); #1;
    rst = 1'b0;
    step(OP_RTYPE, 6'h27, 1'b0, 1'b0, e_fetch_wait, "after_rst_fetch");

    // Unsupported funct traps after EXEC; illegal sticks, no reg_write.
    step(OP_RTYPE, 6'h27, 1'b0, 1'b1, e_fetch_go, "bad_fn_fetch");
    step(OP_RTYPE, 6'h27, 1'b0, 1'b1, e_decode,   "bad_fn_decode");
    step(OP_RTYPE, 6'h27, 1'b0, 1'b1, e_exec_add, "bad_fn_exec");
    for (int i = 0; i < 3; i++) begin
      step(OP_RTYPE, 6'h27, 1'b0, 1'b1, e_trap, "bad_fn_trap");
    end
    rst = 1'b1;
    step(6'h00, 6'h00, 1'b0, 1'b0, e_fetch_wait, "trap_reset_clear");
    rst = 1'b0;

    // Unsupported opcode traps straight from DECODE.
    step(6'h3F, 6'h00, 1'b0, 1'b1, e_fetch_go, "bad_op_fetch");
    step(6'h3F, 6'h00, 1'b0, 1'b1, e_decode,   "bad_op_decode");
    step(6'h3F, 6'h00, 1'b0, 1'b1, e_trap,     "bad_op_trap0");
    step(6'h3F, 6'h00, 1'b0, 1'b1, e_trap,     "bad_op_trap1");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: left=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
